// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU codes,
// sequencer states, instruction classes and the strobe bundle.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_SUB = 5'b00100;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;

  typedef enum logic [3:0] {
    S_F0, S_F1, S_F2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE, C_IMM, C_LDI, C_LD, C_ST, C_BR, C_JR, C_NOP, C_HALT
  } iclass_t;

  typedef struct packed {
    logic       gra;
    logic       grb;
    logic       grc;
    logic       rin;
    logic       rout;
    logic       ba_out;
    logic       pc_out;
    logic       pc_in;
    logic       inc_pc;
    logic       ir_in;
    logic       mar_in;
    logic       mdr_in;
    logic       mdr_out;
    logic       y_in;
    logic       z_in;
    logic       zlow_out;
    logic       c_out;
    logic       con_in;
    logic       read;
    logic       write;
    logic [4:0] alu_op;
    logic       run;
  } strobes_t;

  // Unlisted opcodes fall into C_NOP so they execute as a three-cycle no-op.
  function automatic iclass_t classify(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: return C_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:      return C_IMM;
      OP_LDI:                        return C_LDI;
      OP_LD:                         return C_LD;
      OP_ST:                         return C_ST;
      OP_BR:                         return C_BR;
      OP_JR:                         return C_JR;
      OP_HALT:                       return C_HALT;
      default:                       return C_NOP;
    endcase
  endfunction

  function automatic logic [4:0] alu_code(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: return op;
      OP_ANDI:                       return ALU_AND;
      OP_ORI:                        return ALU_OR;
      default:                       return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational strobe map from sequencer state, latched opcode and CON.
module ctrl_output_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [4:0] opcode,
  input  logic       con,
  output strobes_t   strobes
);

  iclass_t    cls;
  logic [4:0] alu;

  assign cls = classify(opcode);
  assign alu = alu_code(opcode);

  always_comb begin
    // NOTE: every field gets a default first, so no path through the case infers a latch.
    strobes     = '0;
    strobes.run = (state != S_HALT);
    case (state)
      S_F0: begin
        strobes.pc_out = 1'b1; strobes.mar_in = 1'b1;
        strobes.inc_pc = 1'b1; strobes.z_in   = 1'b1;
      end
      S_F1: begin
        strobes.zlow_out = 1'b1; strobes.pc_in  = 1'b1;
        strobes.read     = 1'b1; strobes.mdr_in = 1'b1;
      end
      S_F2: begin
        strobes.mdr_out = 1'b1; strobes.ir_in = 1'b1;
      end
      S_T3: begin
        case (cls)
          C_RTYPE, C_IMM: begin strobes.grb = 1'b1; strobes.rout = 1'b1; strobes.y_in = 1'b1; end
          C_LDI, C_LD, C_ST: begin strobes.grb = 1'b1; strobes.ba_out = 1'b1; strobes.y_in = 1'b1; end
          C_BR: begin strobes.gra = 1'b1; strobes.rout = 1'b1; strobes.con_in = 1'b1; end
          C_JR: begin strobes.gra = 1'b1; strobes.rout = 1'b1; strobes.pc_in = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          C_RTYPE: begin
            strobes.grc = 1'b1; strobes.rout = 1'b1; strobes.alu_op = alu; strobes.z_in = 1'b1;
          end
          C_IMM, C_LDI, C_LD, C_ST: begin
            strobes.c_out = 1'b1; strobes.alu_op = alu; strobes.z_in = 1'b1;
          end
          C_BR: begin strobes.pc_out = 1'b1; strobes.y_in = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          C_RTYPE, C_IMM, C_LDI: begin strobes.zlow_out = 1'b1; strobes.gra = 1'b1; strobes.rin = 1'b1; end
          C_LD, C_ST: begin strobes.zlow_out = 1'b1; strobes.mar_in = 1'b1; end
          C_BR: begin strobes.c_out = 1'b1; strobes.alu_op = alu; strobes.z_in = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          C_LD: begin strobes.read = 1'b1; strobes.mdr_in = 1'b1; end
          C_ST: begin strobes.gra = 1'b1; strobes.rout = 1'b1; strobes.mdr_in = 1'b1; end
          C_BR: begin strobes.zlow_out = con; strobes.pc_in = con; end
          default: ;
        endcase
      end
      S_T7: begin
        case (cls)
          C_LD: begin strobes.mdr_out = 1'b1; strobes.gra = 1'b1; strobes.rin = 1'b1; end
          C_ST: strobes.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore fetch/decode/execute sequencer: state register, opcode latch and
// next-state logic; strobes come from ctrl_output_decode.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [4:0] opcode,
  input  logic       CON,
  input  logic       memReady,
  output logic       Gra,
  output logic       Grb,
  output logic       Grc,
  output logic       Rin,
  output logic       Rout,
  output logic       BAout,
  output logic       PCout,
  output logic       PCin,
  output logic       IncPC,
  output logic       IRin,
  output logic       MARin,
  output logic       MDRin,
  output logic       MDRout,
  output logic       Yin,
  output logic       Zin,
  output logic       Zlowout,
  output logic       Cout,
  output logic       CONin,
  output logic       Read,
  output logic       Write,
  output logic [4:0] aluOp,
  output logic       Run
);

  state_t     state;
  logic [4:0] op_q;
  iclass_t    cls_q;
  strobes_t   dec;
  strobes_t   act;

  assign cls_q = classify(op_q);

  // The opcode is captured on the F2 exit edge so execute cycles never see IR changes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_F0;
      op_q  <= OP_NOP;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register updates together.
      case (state)
        S_F0: state <= S_F1;
        S_F1: if (memReady) state <= S_F2;
        S_F2: begin
          op_q <= opcode;
          case (classify(opcode))
            C_NOP:   state <= S_F0;
            C_HALT:  state <= S_HALT;
            default: state <= S_T3;
          endcase
        end
        S_T3: state <= (cls_q == C_JR) ? S_F0 : S_T4;
        S_T4: state <= S_T5;
        S_T5: state <= (cls_q == C_LD || cls_q == C_ST || cls_q == C_BR) ? S_T6 : S_F0;
        S_T6: begin
          if (cls_q == C_ST)                  state <= S_T7;
          else if (cls_q == C_LD && memReady) state <= S_T7;
          else if (cls_q != C_LD)             state <= S_F0;
        end
        S_T7: if (cls_q == C_LD || memReady) state <= S_F0;
        default: state <= S_HALT;
      endcase
    end
  end

  ctrl_output_decode u_decode (
    .state   (state),
    .opcode  (op_q),
    .con     (CON),
    .strobes (dec)
  );

  // Gating with reset_n blanks every strobe the instant reset asserts, without a clock edge.
  assign act = reset_n ? dec : '0;

  assign Gra     = act.gra;
  assign Grb     = act.grb;
  assign Grc     = act.grc;
  assign Rin     = act.rin;
  assign Rout    = act.rout;
  assign BAout   = act.ba_out;
  assign PCout   = act.pc_out;
  assign PCin    = act.pc_in;
  assign IncPC   = act.inc_pc;
  assign IRin    = act.ir_in;
  assign MARin   = act.mar_in;
  assign MDRin   = act.mdr_in;
  assign MDRout  = act.mdr_out;
  assign Yin     = act.y_in;
  assign Zin     = act.z_in;
  assign Zlowout = act.zlow_out;
  assign Cout    = act.c_out;
  assign CONin   = act.con_in;
  assign Read    = act.read;
  assign Write   = act.write;
  assign aluOp   = act.alu_op;
  assign Run     = act.run;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: per-cycle strobe model built from instruction phase lists,
// a table of instruction lengths measured against a reactive memory, and reset corners.
module tb_control_sequencer;

  logic       clock, reset_n, CON, memReady;
  logic [4:0] opcode, aluOp;
  logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, IRin, MARin, MDRin;
  logic MDRout, Yin, Zin, Zlowout, Cout, CONin, Read, Write, Run;

  control_sequencer dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .CON(CON), .memReady(memReady),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .IRin(IRin), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .Cout(Cout), .CONin(CONin), .Read(Read), .Write(Write), .aluOp(aluOp), .Run(Run)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [25:0] GRA = 26'd1 << 25, GRB = 26'd1 << 24, GRC = 26'd1 << 23;
  localparam logic [25:0] RIN = 26'd1 << 22, ROUT = 26'd1 << 21, BAOUT = 26'd1 << 20;
  localparam logic [25:0] PCOUT = 26'd1 << 19, PCIN = 26'd1 << 18, INCPC = 26'd1 << 17;
  localparam logic [25:0] IRIN = 26'd1 << 16, MARIN = 26'd1 << 15, MDRIN = 26'd1 << 14;
  localparam logic [25:0] MDROUT = 26'd1 << 13, YIN = 26'd1 << 12, ZIN = 26'd1 << 11;
  localparam logic [25:0] ZLOW = 26'd1 << 10, COUT = 26'd1 << 9, CONIN = 26'd1 << 8;
  localparam logic [25:0] READ = 26'd1 << 7, WRITE = 26'd1 << 6, RUN = 26'd1;
  localparam logic [25:0] F0V = PCOUT | MARIN | INCPC | ZIN | RUN;

  typedef struct { logic [25:0] v; bit wait_f; bit con_dep; } step_t;
  typedef struct { logic [4:0] op; logic con; int f1w; int mw; int len; string name; } vec_t;

  step_t q[$];
  vec_t  tbl[12];
  int    n_checks = 0;
  int    n_errors = 0;

  function automatic logic [25:0] outs();
    return {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, IRin, MARin, MDRin,
            MDRout, Yin, Zin, Zlowout, Cout, CONin, Read, Write, aluOp, Run};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ALU function the instruction should request: R-type passes opcode, immediates map, rest add.
  function automatic logic [25:0] alu_of(input logic [4:0] op);
    logic [4:0] a;
    if (op >= 5'd3 && op <= 5'd6) a = op;
    else if (op == 5'd13)         a = 5'd5;
    else if (op == 5'd14)         a = 5'd6;
    else                          a = 5'd3;
    return 26'(a) << 1;
  endfunction

  function automatic void push(input logic [25:0] v, input bit w, input bit c);
    q.push_back('{v | RUN, w, c});
  endfunction

  // Phase list of one instruction, written straight from the instruction descriptions.
  task automatic build(input logic [4:0] op);
    logic [25:0] a;
    a = alu_of(op);
    q.delete();
    push(F0V, 0, 0);
    push(ZLOW | PCIN | READ | MDRIN, 1, 0);
    push(MDROUT | IRIN, 0, 0);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6: begin
        push(GRB | ROUT | YIN, 0, 0); push(GRC | ROUT | a | ZIN, 0, 0); push(ZLOW | GRA | RIN, 0, 0);
      end
      5'd12, 5'd13, 5'd14: begin
        push(GRB | ROUT | YIN, 0, 0); push(COUT | a | ZIN, 0, 0); push(ZLOW | GRA | RIN, 0, 0);
      end
      5'd1: begin
        push(GRB | BAOUT | YIN, 0, 0); push(COUT | a | ZIN, 0, 0); push(ZLOW | GRA | RIN, 0, 0);
      end
      5'd0: begin
        push(GRB | BAOUT | YIN, 0, 0); push(COUT | a | ZIN, 0, 0); push(ZLOW | MARIN, 0, 0);
        push(READ | MDRIN, 1, 0); push(MDROUT | GRA | RIN, 0, 0);
      end
      5'd2: begin
        push(GRB | BAOUT | YIN, 0, 0); push(COUT | a | ZIN, 0, 0); push(ZLOW | MARIN, 0, 0);
        push(GRA | ROUT | MDRIN, 0, 0); push(WRITE, 1, 0);
      end
      5'd18: begin
        push(GRA | ROUT | CONIN, 0, 0); push(PCOUT | YIN, 0, 0); push(COUT | a | ZIN, 0, 0);
        push(26'd0, 0, 1);
      end
      5'd20: push(GRA | ROUT | PCIN, 0, 0);
      default: ;
    endcase
  endtask

  task automatic check_cycle(input string name, input logic [25:0] exp);
    @(negedge clock);
    check(name, 32'(outs()), 32'(exp));
    @(posedge clock);
    #1;
  endtask

  // Starts at F0 just after an edge; noise randomises CON, ignored memReady and post-F2 opcode.
  task automatic run_instr(input string name, input logic [4:0] op, input logic con,
                           input int f1w, input int mw, input bit noise);
    int wcount = 0;
    build(op);
    opcode = op;
    CON    = con;
    for (int i = 0; i < q.size(); i++) begin
      int extra = 0;
      if (q[i].wait_f) begin
        extra = (wcount == 0) ? f1w : mw;
        wcount++;
      end
      for (int k = 0; k <= extra; k++) begin
        memReady = (k == extra);
        if (noise && !q[i].wait_f) memReady = 1'($urandom_range(0, 1));
        if (noise) CON = 1'($urandom_range(0, 1));
        check_cycle(name, (q[i].con_dep && CON) ? (q[i].v | ZLOW | PCIN) : q[i].v);
      end
      if (noise && i == 2) opcode = 5'($urandom_range(0, 31));
    end
  endtask

  // Length in cycles from F0 until F0 comes round again, with a memory model that
  // holds memReady low for the requested number of cycles on each Read/Write.
  task automatic measure(input vec_t v);
    int n = 0;
    int rem = 0;
    bit in_wait = 0;
    bit first = 1;
    bit done = 0;
    opcode = v.op;
    CON    = v.con;
    while (!done && n < 64) begin
      if (Read || Write) begin
        if (!in_wait) begin
          rem = first ? v.f1w : v.mw;
          first = 0;
          in_wait = 1;
        end
        memReady = (rem == 0);
        if (rem > 0) rem--;
      end else begin
        in_wait  = 0;
        memReady = 1'b1;
      end
      @(posedge clock);
      #1;
      n++;
      if (PCout && IncPC) done = 1;
    end
    check({v.name, "_len"}, 32'(n), 32'(v.len));
  endtask

  initial begin
    reset_n = 1'b0; opcode = 5'd0; CON = 1'b0; memReady = 1'b1;
    tbl[0]  = '{5'b00011, 1'b0, 0, 0, 6,  "add"};
    tbl[1]  = '{5'b00000, 1'b0, 3, 2, 13, "ld_w3_2"};
    tbl[2]  = '{5'b10010, 1'b1, 0, 0, 7,  "br_con1"};
    tbl[3]  = '{5'b10010, 1'b0, 0, 0, 7,  "br_con0"};
    tbl[4]  = '{5'b01101, 1'b0, 0, 0, 6,  "andi"};
    tbl[5]  = '{5'b00001, 1'b0, 0, 0, 6,  "ldi"};
    tbl[6]  = '{5'b00010, 1'b0, 0, 0, 8,  "st"};
    tbl[7]  = '{5'b00010, 1'b0, 1, 4, 13, "st_w1_4"};
    tbl[8]  = '{5'b10100, 1'b0, 0, 0, 4,  "jr"};
    tbl[9]  = '{5'b11010, 1'b0, 0, 0, 3,  "nop"};
    tbl[10] = '{5'b11111, 1'b0, 0, 0, 3,  "undef_op"};
    tbl[11] = '{5'b01110, 1'b0, 2, 0, 8,  "ori_w2"};

    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", 32'(outs()), 32'd0);
    reset_n = 1'b1;

    run_instr("add",     5'b00011, 1'b0, 0, 0, 0);
    run_instr("ld_wait", 5'b00000, 1'b0, 3, 2, 0);
    run_instr("br_con1", 5'b10010, 1'b1, 0, 0, 0);
    run_instr("br_con0", 5'b10010, 1'b0, 0, 0, 0);
    run_instr("andi",    5'b01101, 1'b0, 0, 0, 0);

    foreach (tbl[i]) measure(tbl[i]);

    for (int i = 0; i < 150; i++) begin
      logic [4:0] op;
      op = 5'($urandom_range(0, 31));
      if (op == 5'b11011) op = 5'b00100;
      run_instr("random", op, 1'b0, $urandom_range(0, 3), $urandom_range(0, 3), 1);
    end

    // Reset while st is holding Write in T7.
    opcode = 5'b00010; memReady = 1'b1;
    repeat (7) @(posedge clock);
    #1;
    memReady = 1'b0;
    @(negedge clock);
    check("st_t7_write", 32'(outs()), 32'(WRITE | RUN));
    #2 reset_n = 1'b0;
    #1 check("reset_drops_write", 32'(outs()), 32'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    memReady = 1'b1;
    #1 check("after_reset_f0", 32'(outs()), 32'(F0V));

    run_instr("halt", 5'b11011, 1'b0, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      memReady = 1'($urandom_range(0, 1));
      opcode   = 5'($urandom_range(0, 31));
      check_cycle("halted", 26'd0);
    end
    reset_n = 1'b0;
    #2 check("halt_reset", 32'(outs()), 32'd0);
    reset_n = 1'b1;
    run_instr("restart_add", 5'b00011, 1'b0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired Moore control unit that sequences the register-select/encode logic and the rest of the bus-based CPU datapath through fetch, decode and execute. Drives the `Gra`/`Grb`/`Grc`/`Rin`/`Rout`/`BAout` strobes consumed by the IR select logic, plus all bus-source, register-load, ALU and memory strobes. Uses a one-signal ready handshake for memory.

## Interface
Parameters: none.

- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `opcode` in 5: IR[31:27] from the IR select logic.
- `CON` in 1: branch condition flip-flop output.
- `memReady` in 1: memory completed the current Read/Write this cycle.
- `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout` out 1 each: register select/encode strobes.
- `PCout`, `PCin`, `IncPC`, `IRin`, `MARin`, `MDRin`, `MDRout`, `Yin`, `Zin`, `Zlowout`, `Cout`, `CONin` out 1 each: datapath strobes.
- `Read`, `Write` out 1 each: memory requests.
- `aluOp` out 5: ALU function code.
- `Run` out 1: high while executing; low in reset and HALT.

## Operation
- Moore FSM: all outputs decode from the state register only. Any strobe not listed for a state is 0. `aluOp` is 0 except where listed.
- Opcodes:
  - ld 00000, ldi 00001, st 00010
  - add 00011, sub 00100, and 00101, or 00110
  - addi 01100, andi 01101, ori 01110
  - br 10010, jr 10100, nop 11010, halt 11011
  - Any other opcode executes as nop.
- `aluOp` codes: ADD=00011, SUB=00100, AND=00101, OR=00110. R-type passes `opcode`. addi/andi/ori map to ADD/AND/OR. ld/ldi/st/br use ADD.
- Fetch:
  - F0: PCout, MARin, IncPC, Zin.
  - F1: Zlowout, PCin, Read, MDRin. Held until `memReady`=1.
  - F2: MDRout, IRin. Then go to T3.
- R-type:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, aluOp, Zin.
  - T5: Zlowout, Gra, Rin.
  - Then F0.
- Immediate: same as R-type except T4 uses Cout instead of Grc/Rout.
- ldi:
  - T3: Grb, BAout, Yin.
  - T4: Cout, aluOp=ADD, Zin.
  - T5: Zlowout, Gra, Rin.
- ld:
  - T3/T4: as ldi.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin. Held until `memReady`.
  - T7: MDRout, Gra, Rin.
- st:
  - T3–T5: as ld.
  - T6: Gra, Rout, MDRin.
  - T7: Write. Held until `memReady`.
- br:
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Cout, aluOp=ADD, Zin.
  - T6: Zlowout and PCin only if `CON`=1 in that cycle; otherwise no strobes.
- jr: T3: Gra, Rout, PCin.
- nop: leaves F2 directly to F0. No T3 cycle.
- halt: F2 → HALT. HALT is absorbing; `Run`=0; only reset exits.

## Timing
- Reset (async, `reset_n`=0):
  - State forced to F0 immediately; outputs take F0 values only after reset releases.
  - While `reset_n`=0, all outputs are 0, including `Run`.
  - Reset mid-instruction or mid-wait abandons the instruction. No partial strobes follow.
- Each non-wait state lasts exactly 1 cycle.
- Wait states (F1, ld T6, st T7):
  - Advance on the first rising edge with `memReady`=1. Minimum 1 cycle.
  - Strobes are held constant while waiting.
  - `memReady` outside a wait state is ignored.
- Instruction lengths with zero wait (fetch included):
  - nop: 3
  - jr: 4
  - R-type, immediate, ldi: 6
  - br: 7
  - ld, st: 8
  - Each extra `memReady`-low cycle adds 1.
- `opcode` is sampled only on the F2→next edge. `CON` is used only in br T6.

## Structure
- Shared package `cpu_ctrl_pkg`: opcode constants, aluOp constants, state enum (F0, F1, F2, T3–T7, HALT).
- Sub-module `ctrl_output_decode`: combinational map from state plus `opcode` (and `CON` for br T6) to the strobe vector. The top level holds the state register and next-state logic.

## Test plan
- Reset held, then released with `memReady`=1 and opcode add (00011): F0..T5 over 6 cycles. T3 Grb+Rout+Yin, T4 Grc+Rout+Zin with aluOp=00011, T5 Gra+Rin, then F0.
- ld with `memReady` low for 3 cycles in F1 and 2 cycles in T6: instruction takes 13 cycles. Read+MDRin held steady during both waits. T7 shows MDRout+Gra+Rin.
- br with `CON`=1, then br with `CON`=0: PCin+Zlowout in T6 only in the first case. Both take 7 cycles.
- andi (01101): aluOp=00101 in T4, with Cout and no Grc.
- halt (11011): `Run` falls after F2 and stays 0 for 20 cycles with all strobes 0. Pulsing `reset_n` low then high restarts at F0 with `Run`=1.
- Assert `reset_n`=0 during st T7 while `Write` is high: `Write` drops without a clock edge. After release, the first state is F0.
